csr_file: RTL and testbench

CSR_FILE -- requirements
Module: csr_file

---
 rtl/csr_file_pkg.sv | 28 ++
 rtl/csr_file_if.sv | 33 +++
 rtl/csr_file_sync_2ff.sv | 21 ++
 rtl/csr_file.sv | 103 ++++++++++
 tb/tb_csr_file.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/csr_file_pkg.sv
// Shared CSR select encoding and bit positions for the machine-mode CSR file.
package StaticPack;

    typedef enum logic [11:0] {
        CSR_MSTATUS  = 12'h300,
        CSR_MIE      = 12'h304,
        CSR_MTVEC    = 12'h305,
        CSR_MSCRATCH = 12'h340,
        CSR_MEPC     = 12'h341,
        CSR_MCAUSE   = 12'h342,
        CSR_MTVAL    = 12'h343,
        CSR_MIP      = 12'h344,
        CSR_MCYCLE   = 12'hB00,
        CSR_MINSTRET = 12'hB02
    } destinationCSR_;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_MEI = 11;

    localparam logic [31:0] MIE_WMASK = (32'd1 << IRQ_MSI) | (32'd1 << IRQ_MTI) | (32'd1 << IRQ_MEI);

endpackage

// File: rtl/csr_file_if.sv
// Pipeline-facing CSR bus: read port, commit-side write/trap/mret strobes, status outputs.
interface csr_file_if;
    import StaticPack::*;

    logic           interrupt;
    destinationCSR_ readCSR;
    logic [31:0]    csrReadData;
    logic           writeEnable;
    destinationCSR_ writeCSR;
    logic [31:0]    writeData;
    logic           retire;
    logic           trapValid;
    logic [31:0]    trapCause;
    logic [31:0]    trapPC;
    logic [31:0]    trapValue;
    logic           mretValid;
    logic [31:0]    trapVector;
    logic [31:0]    mepcOut;
    logic           interruptPending;

    modport master (
        output interrupt, readCSR, writeEnable, writeCSR, writeData, retire,
               trapValid, trapCause, trapPC, trapValue, mretValid,
        input  csrReadData, trapVector, mepcOut, interruptPending
    );

    modport slave (
        input  interrupt, readCSR, writeEnable, writeCSR, writeData, retire,
               trapValid, trapCause, trapPC, trapValue, mretValid,
        output csrReadData, trapVector, mepcOut, interruptPending
    );

endinterface

// File: rtl/csr_file_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: masked writes, trap entry / MRET, free-running counters,
// synchronized external interrupt and registered interrupt-pending flag.
module csr_file
    import StaticPack::*;
(
    input  logic       clock,
    input  logic       reset,
    csr_file_if.slave  bus
);

    logic        mst_mie, mst_mpie;
    logic [31:0] mie_q, mtvec, mepc, mcause, mtval, mscratch, mcycle, minstret;
    logic        meip, pending;
    logic [31:0] mstatus_val, mip_val;
    logic        wr_ok;

    sync_2ff u_irq_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.interrupt),
        .q     (meip)
    );

    // MSTATUS keeps only MIE/MPIE as state; MPP is hardwired to machine mode.
    always_comb begin
        mstatus_val                               = '0;
        mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_val[MSTATUS_MIE]                  = mst_mie;
        mstatus_val[MSTATUS_MPIE]                 = mst_mpie;
        mip_val                                   = '0;
        mip_val[IRQ_MEI]                          = meip;
    end

    always_comb begin
        bus.csrReadData = '0;
        case (bus.readCSR)
            CSR_MSTATUS:  bus.csrReadData = mstatus_val;
            CSR_MIE:      bus.csrReadData = mie_q;
            CSR_MIP:      bus.csrReadData = mip_val;
            CSR_MTVEC:    bus.csrReadData = mtvec;
            CSR_MEPC:     bus.csrReadData = mepc;
            CSR_MCAUSE:   bus.csrReadData = mcause;
            CSR_MTVAL:    bus.csrReadData = mtval;
            CSR_MSCRATCH: bus.csrReadData = mscratch;
            CSR_MCYCLE:   bus.csrReadData = mcycle;
            CSR_MINSTRET: bus.csrReadData = minstret;
            default:      bus.csrReadData = '0;
        endcase
    end

    assign bus.trapVector       = mtvec;
    assign bus.mepcOut          = mepc;
    assign bus.interruptPending = pending;

    // A write only lands when neither trap nor mret claims the cycle.
    assign wr_ok = bus.writeEnable & ~bus.trapValid & ~bus.mretValid;

    always_ff @(posedge clock) begin
        if (reset) begin
            mst_mie  <= 1'b0;
            mst_mpie <= 1'b0;
            mie_q    <= '0;
            mtvec    <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mscratch <= '0;
            mcycle   <= '0;
            minstret <= '0;
            pending  <= 1'b0;
        end else begin
            pending  <= mst_mie & mie_q[IRQ_MEI] & meip;
            mcycle   <= (wr_ok && bus.writeCSR == CSR_MCYCLE)   ? bus.writeData : mcycle + 32'd1;
            minstret <= (wr_ok && bus.writeCSR == CSR_MINSTRET) ? bus.writeData
                                                                : minstret + {31'd0, bus.retire};
            if (bus.trapValid) begin
                mepc     <= {bus.trapPC[31:2], 2'b00};
                mcause   <= bus.trapCause;
                mtval    <= bus.trapValue;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (bus.mretValid) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (bus.writeEnable) begin
                case (bus.writeCSR)
                    CSR_MSTATUS: begin
                        mst_mie  <= bus.writeData[MSTATUS_MIE];
                        mst_mpie <= bus.writeData[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_q    <= bus.writeData & MIE_WMASK;
                    CSR_MTVEC:    mtvec    <= {bus.writeData[31:2], 2'b00};
                    CSR_MEPC:     mepc     <= {bus.writeData[31:2], 2'b00};
                    CSR_MCAUSE:   mcause   <= bus.writeData;
                    CSR_MTVAL:    mtval    <= bus.writeData;
                    CSR_MSCRATCH: mscratch <= bus.writeData;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: a per-cycle reference model checked at every
// falling edge, plus literal expectations for the key scenarios.
module tb_csr_file;
    import StaticPack::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    csr_file_if bus();

    csr_file dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch, m_mcycle, m_minstret;
    logic        m_pend;
    logic [1:0]  irq_hist;
    bit          model_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input destinationCSR_ s);
        case (s)
            CSR_MSTATUS:  return m_mstatus;
            CSR_MIE:      return m_mie;
            CSR_MIP:      return irq_hist[1] ? 32'h0000_0800 : 32'h0;
            CSR_MTVEC:    return m_mtvec;
            CSR_MEPC:     return m_mepc;
            CSR_MCAUSE:   return m_mcause;
            CSR_MTVAL:    return m_mtval;
            CSR_MSCRATCH: return m_mscratch;
            CSR_MCYCLE:   return m_mcycle;
            CSR_MINSTRET: return m_minstret;
            default:      return 32'h0;
        endcase
    endfunction

    // One clock edge of architectural behaviour, computed from the rules directly.
    task automatic model_step();
        logic        new_pend;
        logic        wrote_cyc, wrote_ins;
        logic [31:0] d;
        if (reset) begin
            m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
            m_mtval = 0; m_mscratch = 0; m_mcycle = 0; m_minstret = 0;
            m_pend = 0; irq_hist = 2'b00;
            return;
        end
        new_pend  = m_mstatus[3] && m_mie[11] && irq_hist[1];
        d         = bus.writeData;
        wrote_cyc = 0;
        wrote_ins = 0;
        if (bus.trapValid) begin
            m_mepc    = bus.trapPC & 32'hFFFF_FFFC;
            m_mcause  = bus.trapCause;
            m_mtval   = bus.trapValue;
            m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
        end else if (bus.mretValid) begin
            m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end else if (bus.writeEnable) begin
            case (bus.writeCSR)
                CSR_MSTATUS:  m_mstatus = 32'h1800 | (d & 32'h88);
                CSR_MIE:      m_mie = d & 32'h888;
                CSR_MTVEC:    m_mtvec = d & 32'hFFFF_FFFC;
                CSR_MEPC:     m_mepc = d & 32'hFFFF_FFFC;
                CSR_MCAUSE:   m_mcause = d;
                CSR_MTVAL:    m_mtval = d;
                CSR_MSCRATCH: m_mscratch = d;
                CSR_MCYCLE:   begin m_mcycle = d; wrote_cyc = 1; end
                CSR_MINSTRET: begin m_minstret = d; wrote_ins = 1; end
                default: ;
            endcase
        end
        if (!wrote_cyc) m_mcycle = m_mcycle + 1;
        if (!wrote_ins && bus.retire) m_minstret = m_minstret + 1;
        m_pend   = new_pend;
        irq_hist = {irq_hist[0], bus.interrupt};
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
        if (reset) model_ok = 1'b1;
    end

    initial forever begin
        @(negedge clock);
        if (model_ok) begin
            chk("model_read", bus.csrReadData, m_read(bus.readCSR));
            chk("model_trapVector", bus.trapVector, m_mtvec);
            chk("model_mepcOut", bus.mepcOut, m_mepc);
            chk("model_pending", {31'd0, bus.interruptPending}, {31'd0, m_pend});
        end
    end

    task automatic idle();
        bus.writeEnable = 0; bus.writeCSR = CSR_MSCRATCH; bus.writeData = 0;
        bus.retire = 0; bus.trapValid = 0; bus.trapCause = 0; bus.trapPC = 0;
        bus.trapValue = 0; bus.mretValid = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #2;
        idle();
    endtask

    task automatic wr(input destinationCSR_ s, input logic [31:0] v);
        bus.writeEnable = 1; bus.writeCSR = s; bus.writeData = v;
        step();
    endtask

    task automatic expect_csr(input string name, input destinationCSR_ s, input logic [31:0] v);
        bus.readCSR = s;
        #1;
        chk(name, bus.csrReadData, v);
    endtask

    initial begin
        idle();
        bus.interrupt = 0;
        bus.readCSR   = CSR_MSTATUS;
        reset = 1;
        step();
        step();
        expect_csr("reset_mstatus", CSR_MSTATUS, 32'h0000_1800);
        expect_csr("reset_mie", CSR_MIE, 32'h0);
        chk("reset_trapVector", bus.trapVector, 32'h0);
        chk("reset_pending", {31'd0, bus.interruptPending}, 32'h0);
        reset = 0;

        wr(CSR_MTVEC, 32'h0000_0103);
        chk("mtvec_out", bus.trapVector, 32'h0000_0100);
        expect_csr("mtvec_read", CSR_MTVEC, 32'h0000_0100);
        wr(CSR_MEPC, 32'hFFFF_FFFF);
        expect_csr("mepc_mask", CSR_MEPC, 32'hFFFF_FFFC);
        wr(CSR_MIE, 32'hFFFF_FFFF);
        expect_csr("mie_mask", CSR_MIE, 32'h0000_0888);
        wr(CSR_MSTATUS, 32'hFFFF_FFFF);
        expect_csr("mstatus_mask", CSR_MSTATUS, 32'h0000_1888);
        wr(CSR_MIP, 32'hFFFF_FFFF);
        expect_csr("mip_ro", CSR_MIP, 32'h0);
        expect_csr("unimpl", destinationCSR_'(12'h123), 32'h0);

        wr(CSR_MSTATUS, 32'h8);
        wr(CSR_MSCRATCH, 32'h0000_AAAA);
        bus.trapValid = 1; bus.trapPC = 32'h80; bus.trapCause = 32'h0B; bus.trapValue = 0;
        step();
        expect_csr("trap_mepc", CSR_MEPC, 32'h80);
        expect_csr("trap_mcause", CSR_MCAUSE, 32'h0B);
        expect_csr("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);
        bus.mretValid = 1;
        step();
        expect_csr("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

        wr(CSR_MSTATUS, 32'h8);
        bus.trapValid = 1; bus.trapPC = 32'h1237; bus.trapCause = 32'h8000_000B; bus.trapValue = 32'hDEAD;
        bus.mretValid = 1;
        bus.writeEnable = 1; bus.writeCSR = CSR_MSCRATCH; bus.writeData = 32'h1234;
        step();
        expect_csr("prio_mscratch", CSR_MSCRATCH, 32'h0000_AAAA);
        expect_csr("prio_mstatus", CSR_MSTATUS, 32'h0000_1880);
        expect_csr("prio_mepc", CSR_MEPC, 32'h0000_1234);
        expect_csr("prio_mtval", CSR_MTVAL, 32'h0000_DEAD);
        bus.mretValid = 1;
        bus.writeEnable = 1; bus.writeCSR = CSR_MSCRATCH; bus.writeData = 32'h1234;
        step();
        expect_csr("mret_drop_wr", CSR_MSCRATCH, 32'h0000_AAAA);
        expect_csr("mret_mstatus2", CSR_MSTATUS, 32'h0000_1888);

        bus.readCSR = CSR_MSCRATCH;
        bus.writeEnable = 1; bus.writeCSR = CSR_MSCRATCH; bus.writeData = 32'h5555;
        #1 chk("read_old", bus.csrReadData, 32'h0000_AAAA);
        step();
        expect_csr("read_new", CSR_MSCRATCH, 32'h0000_5555);

        wr(CSR_MCYCLE, 32'hFFFF_FFFE);
        expect_csr("mcycle_wr", CSR_MCYCLE, 32'hFFFF_FFFE);
        step();
        expect_csr("mcycle_max", CSR_MCYCLE, 32'hFFFF_FFFF);
        step();
        expect_csr("mcycle_wrap", CSR_MCYCLE, 32'h0);
        bus.retire = 1;
        wr(CSR_MINSTRET, 32'h5);
        expect_csr("minstret_wr", CSR_MINSTRET, 32'h5);
        bus.retire = 1;
        step();
        expect_csr("minstret_inc", CSR_MINSTRET, 32'h6);
        step();
        expect_csr("minstret_hold", CSR_MINSTRET, 32'h6);

        bus.interrupt = 1;
        step();
        expect_csr("mip_c1", CSR_MIP, 32'h0);
        step();
        expect_csr("mip_c2", CSR_MIP, 32'h0000_0800);
        chk("pend_c2", {31'd0, bus.interruptPending}, 32'h0);
        step();
        chk("pend_c3", {31'd0, bus.interruptPending}, 32'h1);
        wr(CSR_MSTATUS, 32'h0);
        step();
        chk("pend_drop", {31'd0, bus.interruptPending}, 32'h0);

        reset = 1;
        bus.trapValid = 1; bus.trapPC = 32'h100; bus.trapCause = 32'h3;
        bus.writeEnable = 1; bus.writeCSR = CSR_MSCRATCH; bus.writeData = 32'h77;
        step();
        expect_csr("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
        expect_csr("rst_mepc", CSR_MEPC, 32'h0);
        expect_csr("rst_mcause", CSR_MCAUSE, 32'h0);
        expect_csr("rst_mscratch", CSR_MSCRATCH, 32'h0);
        expect_csr("rst_mie", CSR_MIE, 32'h0);
        expect_csr("rst_minstret", CSR_MINSTRET, 32'h0);
        expect_csr("rst_mcycle", CSR_MCYCLE, 32'h0);
        expect_csr("rst_mip", CSR_MIP, 32'h0);
        chk("rst_mepcOut", bus.mepcOut, 32'h0);
        chk("rst_pending", {31'd0, bus.interruptPending}, 32'h0);
        reset = 0;
        bus.interrupt = 0;
        bus.readCSR = CSR_MCYCLE;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
